// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher: parses 3-byte command frames (header, cmd, ~cmd) from
// the UART receiver, then drives SysState/Enable to the measurement blocks
// until they report Done. Byte-gap and Done waits are bounded by timers.
module uart_cmd_dispatcher #(
  parameter logic [7:0]  HeaderByte = 8'h55,
  parameter logic [7:0]  CmdMax     = 8'h0F,
  parameter logic [7:0]  IdleState  = 8'h00,
  parameter logic [19:0] GapLimit   = 20'd500000,
  parameter logic [23:0] DoneLimit  = 24'd10000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       UARTDatReady,
  input  logic [7:0] UARTReceive,
  input  logic       Done,
  output logic [7:0] SysState,
  output logic       Enable,
  output logic       Busy,
  output logic       CmdErr,
  output logic [1:0] ErrCode
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_CHK, S_WAIT, S_REL} state_t;

  state_t      state, state_n;
  logic [7:0]  cmd, cmd_n;
  logic [7:0]  sys_n;
  logic        en_n, err_n;
  logic [1:0]  code_n;
  logic [19:0] gap_cnt, gap_n, gap_inc;
  logic [23:0] done_cnt, done_n, done_inc;
  logic        gap_to, done_to, cmd_ok;

  // Saturating increments and limit detection for both timers.
  assign gap_inc  = (gap_cnt == '1) ? gap_cnt : gap_cnt + 20'd1;
  assign done_inc = (done_cnt == '1) ? done_cnt : done_cnt + 24'd1;
  assign gap_to   = (gap_inc >= GapLimit);
  assign done_to  = (done_inc >= DoneLimit);
  assign cmd_ok   = (UARTReceive == ~cmd) && (cmd >= 8'd1) && (cmd <= CmdMax);
  assign Busy     = (state != S_IDLE);

  // State and registered outputs; reset aborts any frame or measurement silently.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      cmd      <= 8'h00;
      SysState <= IdleState;
      Enable   <= 1'b0;
      CmdErr   <= 1'b0;
      ErrCode  <= 2'd0;
      gap_cnt  <= 20'd0;
      done_cnt <= 24'd0;
    end else begin
      state    <= state_n;
      cmd      <= cmd_n;
      SysState <= sys_n;
      Enable   <= en_n;
      CmdErr   <= err_n;
      ErrCode  <= code_n;
      gap_cnt  <= gap_n;
      done_cnt <= done_n;
    end
  end

  // Frame parsing, handshake sequencing and timeout handling.
  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    sys_n   = SysState;
    en_n    = Enable;
    err_n   = 1'b0;
    code_n  = ErrCode;
    gap_n   = gap_cnt;
    done_n  = done_cnt;
    case (state)
      S_IDLE: begin
        if (UARTDatReady && UARTReceive == HeaderByte) begin
          state_n = S_CMD;
          gap_n   = 20'd0;
        end
      end
      S_CMD: begin
        // A byte in the limit cycle wins over the timeout.
        if (UARTDatReady) begin
          cmd_n   = UARTReceive;
          state_n = S_CHK;
          gap_n   = 20'd0;
        end else if (gap_to) begin
          err_n   = 1'b1;
          code_n  = 2'd2;
          state_n = S_IDLE;
          gap_n   = 20'd0;
        end else begin
          gap_n = gap_inc;
        end
      end
      S_CHK: begin
        if (UARTDatReady) begin
          gap_n = 20'd0;
          if (cmd_ok) begin
            sys_n   = cmd;
            en_n    = 1'b1;
            done_n  = 24'd0;
            state_n = S_WAIT;
          end else begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = S_IDLE;
          end
        end else if (gap_to) begin
          err_n   = 1'b1;
          code_n  = 2'd2;
          state_n = S_IDLE;
          gap_n   = 20'd0;
        end else begin
          gap_n = gap_inc;
        end
      end
      S_WAIT: begin
        // Done in the limit cycle counts as success.
        done_n = done_inc;
        if (Done) begin
          en_n    = 1'b0;
          state_n = S_REL;
        end else if (done_to) begin
          en_n    = 1'b0;
          err_n   = 1'b1;
          code_n  = 2'd3;
          state_n = S_REL;
        end
      end
      S_REL: begin
        en_n = 1'b0;
        if (!Done) begin
          sys_n   = IdleState;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        en_n    = 1'b0;
        sys_n   = IdleState;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Directed bench for uart_cmd_dispatcher with a frame-level reference model
// checked every cycle, plus literal spot checks at the interesting edges.
module tb_uart_cmd_dispatcher;

  localparam int GL = 100;
  localparam int DL = 1000;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       UARTDatReady = 1'b0;
  logic [7:0] UARTReceive = 8'h00;
  logic       Done = 1'b0;
  logic [7:0] SysState;
  logic       Enable, Busy, CmdErr;
  logic [1:0] ErrCode;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_dispatcher #(
    .HeaderByte(8'h55), .CmdMax(8'h0F), .IdleState(8'h00),
    .GapLimit(20'(GL)), .DoneLimit(24'(DL))
  ) dut (
    .Clk(Clk), .Rst(Rst), .UARTDatReady(UARTDatReady), .UARTReceive(UARTReceive),
    .Done(Done), .SysState(SysState), .Enable(Enable), .Busy(Busy),
    .CmdErr(CmdErr), .ErrCode(ErrCode)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects frame bytes in a queue and tracks the
  // measurement as "active" then "releasing", counting cycles as it goes.
  logic [7:0] frame[$];
  int         gap, wait_cyc;
  bit         active, releasing;
  logic [7:0] m_sys;
  logic       m_en, m_err, m_busy;
  logic [1:0] m_code;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      frame.delete();
      gap = 0; wait_cyc = 0; active = 0; releasing = 0;
      m_sys = 8'h00; m_en = 0; m_err = 0; m_code = 0;
    end else begin
      m_err = 0;
      if (releasing) begin
        if (!Done) begin releasing = 0; m_sys = 8'h00; end
      end else if (active) begin
        wait_cyc++;
        if (Done) begin
          active = 0; releasing = 1; m_en = 0;
        end else if (wait_cyc == DL) begin
          active = 0; releasing = 1; m_en = 0; m_err = 1; m_code = 3;
        end
      end else if (frame.size() == 0) begin
        if (UARTDatReady && UARTReceive == 8'h55) begin frame.push_back(UARTReceive); gap = 0; end
      end else if (UARTDatReady) begin
        frame.push_back(UARTReceive);
        gap = 0;
        if (frame.size() == 3) begin
          if ((frame[1] ^ frame[2]) == 8'hFF && frame[1] != 0 && frame[1] <= 8'h0F) begin
            active = 1; wait_cyc = 0; m_sys = frame[1]; m_en = 1;
          end else begin
            m_err = 1; m_code = 1;
          end
          frame.delete();
        end
      end else begin
        gap++;
        if (gap == GL) begin m_err = 1; m_code = 2; frame.delete(); gap = 0; end
      end
    end
    m_busy = (frame.size() != 0) || active || releasing;
  end

  // Every-cycle comparison against the model.
  int err_pulses = 0;
  always @(negedge Clk) begin
    if (Rst) begin
      chk("SysState", SysState, m_sys);
      chk("Enable", Enable, m_en);
      chk("Busy", Busy, m_busy);
      chk("CmdErr", CmdErr, m_err);
      chk("ErrCode", ErrCode, m_code);
      if (CmdErr) err_pulses++;
    end
  end

  // Stimulus helpers; all entered and left at posedge+2.
  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    UARTDatReady = 1'b1;
    UARTReceive  = b;
    @(posedge Clk); #2;
    UARTDatReady = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] k);
    send_byte(8'h55); idle(1);
    send_byte(c);     idle(1);
    send_byte(k);
  endtask

  task automatic finish_meas();
    Done = 1'b1; idle(3);
    Done = 1'b0; idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    chk("rst SysState", SysState, 8'h00);
    chk("rst Enable", Enable, 1'b0);
    chk("rst Busy", Busy, 1'b0);
    chk("rst CmdErr", CmdErr, 1'b0);
    chk("rst ErrCode", ErrCode, 2'd0);
    idle(2); Rst = 1'b1; idle(2);

    // Valid frame, Done 40 cycles after Enable.
    send_frame(8'h05, 8'hFA);
    chk("valid Enable latency", Enable, 1'b1);
    chk("valid SysState", SysState, 8'h05);
    idle(39); Done = 1'b1; idle(1);
    chk("done Enable drop", Enable, 1'b0);
    chk("done SysState held", SysState, 8'h05);
    idle(2); Done = 1'b0; idle(1);
    chk("release SysState", SysState, 8'h00);
    chk("release Busy", Busy, 1'b0);
    chk("valid no errors", err_pulses, 0);
    idle(3);

    // Bad checksum and illegal codes.
    send_frame(8'h05, 8'hFB);
    chk("badchk CmdErr", CmdErr, 1'b1);
    chk("badchk ErrCode", ErrCode, 2'd1);
    idle(2);
    send_frame(8'h00, 8'hFF); idle(2);
    send_frame(8'h10, 8'hEF); idle(2);
    chk("bad frames pulses", err_pulses, 3);
    chk("bad frames Enable", Enable, 1'b0);

    // Header in CMD position is data; 0x55 is illegal.
    send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
    chk("hdr-as-data ErrCode", ErrCode, 2'd1);
    chk("hdr-as-data CmdErr", CmdErr, 1'b1);
    idle(2);

    // Top legal code, Done already high in IDLE is ignored beforehand.
    Done = 1'b1; idle(3); Done = 1'b0;
    chk("idle Done ignored", Busy, 1'b0);
    send_frame(8'h0F, 8'hF0);
    chk("cmdmax accepted", SysState, 8'h0F);
    idle(2); finish_meas();

    // Gap: byte in the limit cycle wins, then a real timeout.
    send_byte(8'h55); idle(GL - 1);
    send_byte(8'h05);
    chk("gap byte wins", CmdErr, 1'b0);
    idle(GL - 1);
    chk("gap before limit", CmdErr, 1'b0);
    chk("gap before Busy", Busy, 1'b1);
    idle(1);
    chk("gap CmdErr", CmdErr, 1'b1);
    chk("gap ErrCode", ErrCode, 2'd2);
    chk("gap Busy", Busy, 1'b0);
    idle(2);
    send_frame(8'h05, 8'hFA);
    chk("after gap accepted", Enable, 1'b1);
    idle(4); finish_meas();

    // Done timeout.
    send_frame(8'h03, 8'hFC);
    idle(DL - 1);
    chk("dl before Enable", Enable, 1'b1);
    idle(1);
    chk("dl Enable", Enable, 1'b0);
    chk("dl CmdErr", CmdErr, 1'b1);
    chk("dl ErrCode", ErrCode, 2'd3);
    idle(1);
    chk("dl SysState idle", SysState, 8'h00);
    idle(2);

    // Done exactly in the limit cycle is success.
    send_frame(8'h04, 8'hFB);
    idle(DL - 1); Done = 1'b1; idle(1);
    chk("dl-edge Enable", Enable, 1'b0);
    chk("dl-edge CmdErr", CmdErr, 1'b0);
    Done = 1'b0; idle(3);

    // Bytes during WAIT are ignored.
    send_frame(8'h05, 8'hFA); idle(3);
    send_frame(8'h02, 8'hFD); idle(5);
    chk("wait bytes SysState", SysState, 8'h05);
    finish_meas(); idle(5);
    chk("no spurious Enable", Enable, 1'b0);
    chk("no spurious Busy", Busy, 1'b0);

    // Async reset during WAIT.
    send_frame(8'h05, 8'hFA); idle(5);
    Rst = 1'b0; #1;
    chk("arst Enable", Enable, 1'b0);
    chk("arst SysState", SysState, 8'h00);
    chk("arst Busy", Busy, 1'b0);
    idle(2); Rst = 1'b1; idle(2);
    send_frame(8'h01, 8'hFE);
    chk("post-rst Enable", Enable, 1'b1);
    chk("post-rst SysState", SysState, 8'h01);
    idle(3); finish_meas(); idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Receive-side counterpart of the measurement blocks that stream results out over UART.
- Parses 3-byte command frames from the UART receiver, validates each frame, then drives SysState/Enable to the measurement modules.
- Holds Enable until the selected module reports Done, then releases the handshake and returns to idle.
- Sits between the UART RX core and all SysState/Enable/Done consumers.

Parameters:
HeaderByte, 8'h55, frame start byte
CmdMax, 8'h0F, highest legal command code; legal codes are 8'h01..CmdMax
IdleState, 8'h00, SysState value driven when no command is active
GapLimit, 20'd500000, max Clk cycles allowed between consecutive frame bytes
DoneLimit, 24'd10000000, max Clk cycles to wait for Done after Enable rises

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  asynchronous reset, active-low
UARTDatReady  input  1  one-cycle pulse, UARTReceive valid
UARTReceive  input  8  received byte
Done  input  1  OR of downstream done flags, level
SysState  output  8  command code for downstream modules, registered
Enable  output  1  downstream enable, registered level
Busy  output  1  high in every state except S_IDLE
CmdErr  output  1  one-cycle pulse on any rejected frame or timeout
ErrCode  output  2  cause of the last CmdErr: 1 = checksum or illegal code, 2 = byte-gap timeout, 3 = Done timeout; held until the next error

Behaviour:
- Reset (async, Rst=0): state S_IDLE, SysState=IdleState, Enable=0, Busy=0, CmdErr=0, ErrCode=0, both timers=0, command register=0. Reset mid-frame or mid-measurement aborts immediately; no error is flagged.
- Frame format: HeaderByte, CMD, CHK, where CHK must equal ~CMD. Only a cycle with UARTDatReady=1 consumes a byte.
- S_IDLE:
  - Byte == HeaderByte -> S_CMD, gap timer cleared.
  - Any other byte is discarded silently.
- S_CMD: next byte is latched as CMD -> S_CHK, gap timer cleared.
- S_CHK: next byte is checked.
  - If CHK == ~CMD and 1 <= CMD <= CmdMax: on the following clock SysState=CMD and Enable=1 in the same cycle, state S_WAIT. Latency is 1 cycle from the CHK pulse to Enable high.
  - Otherwise: CmdErr pulse, ErrCode=1, return to S_IDLE.
- Gap timer (S_CMD and S_CHK only): increments every cycle without UARTDatReady.
  - On reaching GapLimit: CmdErr pulse, ErrCode=2, return to S_IDLE; the partial frame is discarded.
  - A byte arriving in the same cycle the timer reaches GapLimit wins; no timeout is taken.
- S_WAIT: SysState and Enable held; Done timer increments.
  - Done=1 -> Enable=0 next cycle, state S_REL.
  - Done timer reaches DoneLimit with Done=0 -> Enable=0, CmdErr pulse, ErrCode=3, state S_REL.
  - Done=1 in the limit cycle counts as success.
- S_REL: Enable=0, SysState still = CMD.
  - Waits until Done=0, then SysState=IdleState and state S_IDLE.
  - Minimum 1 cycle in S_REL, even if Done is already low.
- UARTDatReady pulses in S_WAIT/S_REL: bytes discarded, no error. The header search restarts only in S_IDLE.
- A header byte inside the CMD/CHK positions is treated as data, with no resync. For example, frame 55 55 AA decodes as CMD=0x55 with a valid CHK; 0x55 > CmdMax, so it is rejected with ErrCode=1.
- Done=1 while in S_IDLE is ignored.
- CmdErr is high for exactly one cycle per error. No two errors can occur in the same cycle.
- Timers saturate and never wrap. Timer widths are 20 and 24 bits as per the parameter defaults.

Test Plan:
- Valid frame 55 05 FA, Done raised 40 cycles after Enable -> Enable=1 and SysState=05 1 cycle after the FA pulse; Enable=0 1 cycle after Done; SysState=00 after Done falls; CmdErr never asserted.
- Bad checksum 55 05 FB, then illegal codes 55 00 FF and 55 10 EF -> three CmdErr pulses, ErrCode=1, Enable stays 0, SysState stays 00.
- GapLimit=100: send 55, 05, then nothing for 100 cycles -> CmdErr with ErrCode=2 exactly at 100 cycles, state idle. Then 55 05 FA -> accepted normally.
- DoneLimit=1000, frame 55 03 FC, Done held 0 -> Enable drops at cycle 1000 with CmdErr and ErrCode=3; SysState returns to 00 (Done low).
- Bytes 55 02 FD sent while in S_WAIT for cmd 05 -> ignored; after Done and release, no spurious Enable occurs.
- Assert Rst during S_WAIT with Enable=1 -> Enable=0, SysState=00, Busy=0 immediately (asynchronous); the next valid frame is accepted.
